// File: rtl/wb_ext_arbiter_pkg.sv
// rtl/wb_ext_arbiter_pkg.sv - shared types and bus widths for the external Wishbone arbiter
// Contents: arb_state_t (IDLE/BUSY/ABORT), WB_AW/WB_DW data and address widths.
package wb_arb_pkg;
    localparam int WB_AW = 32;
    localparam int WB_DW = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY  = 2'd1,
        ABORT = 2'd2
    } arb_state_t;
endpackage

// File: rtl/wb_ext_arbiter_if.sv
// rtl/wb_ext_arbiter_if.sv - bundle of requester-side and slave-side Wishbone signals
// Master side: m_cyc/m_stb/m_we/m_addr/m_wdata/m_sel in, m_rdata/m_ack/m_err out.
// Slave side:  wb_cyc/wb_stb/wb_we/wb_addr/wb_wdata/wb_sel out, wb_rdata/wb_ack_ext in.
// Status:      grant (current owner index), busy.
// Modport master is the environment (requesters plus the external slave);
// modport slave is the arbiter itself.
interface wb_ext_arbiter_if #(
    parameter int NUM_M = 2
);
    import wb_arb_pkg::*;

    localparam int GW = (NUM_M > 1) ? $clog2(NUM_M) : 1;

    logic [NUM_M-1:0]       m_cyc;
    logic [NUM_M-1:0]       m_stb;
    logic [NUM_M-1:0]       m_we;
    logic [NUM_M*WB_AW-1:0] m_addr;
    logic [NUM_M*WB_DW-1:0] m_wdata;
    logic [NUM_M*4-1:0]     m_sel;
    logic [WB_DW-1:0]       m_rdata;
    logic [NUM_M-1:0]       m_ack;
    logic [NUM_M-1:0]       m_err;

    logic                   wb_cyc;
    logic                   wb_stb;
    logic                   wb_we;
    logic [WB_AW-1:0]       wb_addr;
    logic [WB_DW-1:0]       wb_wdata;
    logic [3:0]             wb_sel;
    logic [WB_DW-1:0]       wb_rdata;
    logic                   wb_ack_ext;

    logic [GW-1:0]          grant;
    logic                   busy;

    modport master (
        output m_cyc, m_stb, m_we, m_addr, m_wdata, m_sel,
        input  m_rdata, m_ack, m_err,
        input  wb_cyc, wb_stb, wb_we, wb_addr, wb_wdata, wb_sel,
        output wb_rdata, wb_ack_ext,
        input  grant, busy
    );

    modport slave (
        input  m_cyc, m_stb, m_we, m_addr, m_wdata, m_sel,
        output m_rdata, m_ack, m_err,
        output wb_cyc, wb_stb, wb_we, wb_addr, wb_wdata, wb_sel,
        input  wb_rdata, wb_ack_ext,
        output grant, busy
    );
endinterface

// File: rtl/wb_ext_arbiter_rr_pick.sv
// rtl/wb_ext_arbiter_rr_pick.sv - combinational round-robin requester selector
// Ports: i_req (request vector), i_last (previous owner),
//        o_idx (first requester at or after i_last+1, wrapping), o_valid (any request).
module rr_pick #(
    parameter int NUM_M = 2,
    parameter int GW    = (NUM_M > 1) ? $clog2(NUM_M) : 1
) (
    input  logic [NUM_M-1:0] i_req,
    input  logic [GW-1:0]    i_last,
    output logic [GW-1:0]    o_idx,
    output logic             o_valid
);
    always_comb begin
        int w_cand;
        o_idx  = '0;
        w_cand = 0;
        // Walk offsets from farthest to nearest so the nearest requester
        // after i_last is the one left in o_idx.
        for (int k = NUM_M; k >= 1; k--) begin
            w_cand = (int'(i_last) + k) % NUM_M;
            if (i_req[w_cand]) begin
                o_idx = GW'(w_cand);
            end
        end
    end

    assign o_valid = |i_req;
endmodule

// File: rtl/wb_ext_arbiter.sv
// rtl/wb_ext_arbiter.sv - round-robin arbiter sharing one external Wishbone slave port
// Ports: clk, rst (synchronous, active high), bus (wb_ext_arbiter_if.slave).
// One owner per bus cycle; the owner's signals pass straight through while
// BUSY. A watchdog aborts a strobe left unacknowledged for TIMEOUT cycles
// with a one-cycle m_err pulse to the owner.
module wb_ext_arbiter
    import wb_arb_pkg::*;
#(
    parameter int NUM_M   = 2,
    parameter int TIMEOUT = 16
) (
    input  logic                clk,
    input  logic                rst,
    wb_ext_arbiter_if.slave     bus
);
    localparam int GW = (NUM_M > 1) ? $clog2(NUM_M) : 1;
    localparam int WW = $clog2(TIMEOUT) + 1;
    localparam logic [WW-1:0] WDT_LAST = WW'(TIMEOUT - 1);

    arb_state_t     r_state;
    logic [GW-1:0]  r_grant;
    logic [GW-1:0]  r_last;
    logic [WW-1:0]  r_wdt;

    logic [NUM_M-1:0] w_req;
    logic [GW-1:0]    w_pick_idx;
    logic             w_pick_valid;
    logic             w_own_cyc;
    logic             w_own_stb;

    assign w_req     = bus.m_cyc & bus.m_stb;
    assign w_own_cyc = bus.m_cyc[r_grant];
    assign w_own_stb = bus.m_stb[r_grant];

    rr_pick #(
        .NUM_M (NUM_M),
        .GW    (GW)
    ) u_pick (
        .i_req   (w_req),
        .i_last  (r_last),
        .o_idx   (w_pick_idx),
        .o_valid (w_pick_valid)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_grant <= '0;
            r_last  <= GW'(NUM_M - 1);
            r_wdt   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_pick_valid) begin
                        r_grant <= w_pick_idx;
                        r_wdt   <= '0;
                        r_state <= BUSY;
                    end
                end
                BUSY: begin
                    if (!w_own_cyc) begin
                        r_last  <= r_grant;
                        r_state <= IDLE;
                    end else if (bus.wb_ack_ext) begin
                        // An ack on the final watchdog cycle still completes normally.
                        r_wdt <= '0;
                    end else if (w_own_stb) begin
                        if (r_wdt == WDT_LAST) begin
                            r_state <= ABORT;
                        end else begin
                            r_wdt <= r_wdt + WW'(1);
                        end
                    end
                end
                ABORT: begin
                    // Recording the aborted owner as last hands priority to the others.
                    r_last  <= r_grant;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    always_comb begin
        bus.wb_cyc   = 1'b0;
        bus.wb_stb   = 1'b0;
        bus.wb_we    = 1'b0;
        bus.wb_addr  = '0;
        bus.wb_wdata = '0;
        bus.wb_sel   = '0;
        bus.m_ack    = '0;
        bus.m_err    = '0;
        if (r_state == BUSY) begin
            bus.wb_cyc          = w_own_cyc;
            bus.wb_stb          = w_own_stb;
            bus.wb_we           = bus.m_we[r_grant];
            bus.wb_addr         = bus.m_addr[WB_AW*r_grant +: WB_AW];
            bus.wb_wdata        = bus.m_wdata[WB_DW*r_grant +: WB_DW];
            bus.wb_sel          = bus.m_sel[4*r_grant +: 4];
            bus.m_ack[r_grant]  = bus.wb_ack_ext;
        end else if (r_state == ABORT) begin
            bus.m_err[r_grant]  = 1'b1;
        end
    end

    assign bus.m_rdata = bus.wb_rdata;
    assign bus.grant   = r_grant;
    assign bus.busy    = (r_state != IDLE);
endmodule

// File: tb/tb_wb_ext_arbiter.sv
// tb/tb_wb_ext_arbiter.sv - self-checking bench for wb_ext_arbiter
module tb_wb_ext_arbiter;
    import wb_arb_pkg::*;

    localparam int NM = 2;
    localparam int TO = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    wb_ext_arbiter_if #(.NUM_M(NM)) bus ();

    wb_ext_arbiter #(.NUM_M(NM), .TIMEOUT(TO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic        rst;
        logic [1:0]  cyc;
        logic [1:0]  stb;
        logic        ack;
        logic [1:0]  e_ack;
        logic [1:0]  e_err;
        logic        e_cyc;
        logic        e_stb;
        logic        e_grant;
        logic        e_busy;
        logic [31:0] e_addr;
    } vec_t;

    vec_t tbl[14];

    task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] cyc, input logic [1:0] stb, input logic ack);
        bus.m_cyc      = cyc;
        bus.m_stb      = stb;
        bus.wb_ack_ext = ack;
    endtask

    function automatic logic [39:0] obs_short();
        return {bus.m_ack, bus.m_err, bus.wb_cyc, bus.wb_stb, bus.grant, bus.busy, bus.wb_addr};
    endfunction

    function automatic logic [76:0] obs_full();
        return {bus.m_ack, bus.m_err, bus.wb_cyc, bus.wb_stb, bus.wb_we, bus.grant, bus.busy,
                bus.wb_sel, bus.wb_addr, bus.wb_wdata};
    endfunction

    // Reference model: who owns the port, how long the current strobe has
    // waited, and whether this cycle is the abort cycle.
    int md_phase;   // 0 free, 1 owned, 2 aborting
    int md_grant;
    int md_last;
    int md_wait;

    task automatic model_reset();
        md_phase = 0;
        md_grant = 0;
        md_last  = NM - 1;
        md_wait  = 0;
    endtask

    function automatic logic [76:0] model_expect();
        logic [1:0]  e_ack, e_err;
        logic        e_cyc, e_stb, e_we;
        logic [3:0]  e_sel;
        logic [31:0] e_addr, e_wdata;
        e_ack = '0; e_err = '0; e_cyc = 0; e_stb = 0; e_we = 0;
        e_sel = '0; e_addr = '0; e_wdata = '0;
        if (md_phase == 1) begin
            e_cyc   = bus.m_cyc[md_grant];
            e_stb   = bus.m_stb[md_grant];
            e_we    = bus.m_we[md_grant];
            e_sel   = bus.m_sel[4*md_grant +: 4];
            e_addr  = bus.m_addr[32*md_grant +: 32];
            e_wdata = bus.m_wdata[32*md_grant +: 32];
            e_ack[md_grant] = bus.wb_ack_ext;
        end else if (md_phase == 2) begin
            e_err[md_grant] = 1'b1;
        end
        return {e_ack, e_err, e_cyc, e_stb, e_we, 1'(md_grant), (md_phase != 0), e_sel, e_addr, e_wdata};
    endfunction

    task automatic model_step();
        logic [NM-1:0] req;
        if (rst) begin
            model_reset();
        end else if (md_phase == 0) begin
            req = bus.m_cyc & bus.m_stb;
            for (int k = NM; k >= 1; k--) begin
                if (req[(md_last + k) % NM]) md_grant = (md_last + k) % NM;
            end
            if (req != 0) begin
                md_phase = 1;
                md_wait  = 0;
            end
        end else if (md_phase == 1) begin
            if (!bus.m_cyc[md_grant]) begin
                md_last  = md_grant;
                md_phase = 0;
            end else if (bus.wb_ack_ext) begin
                md_wait = 0;
            end else if (bus.m_stb[md_grant]) begin
                md_wait++;
                if (md_wait == TO) md_phase = 2;
            end
        end else begin
            md_last  = md_grant;
            md_phase = 0;
        end
    endtask

    initial begin
        int err_cnt, err_at, ack_cnt, ack_at;
        logic [1:0] err_vec;
        logic cyc_at_err;

        tbl[0]  = '{0, 2'b01, 2'b01, 0, 2'b00, 2'b00, 0, 0, 0, 0, 32'h0};
        tbl[1]  = '{0, 2'b01, 2'b01, 0, 2'b00, 2'b00, 1, 1, 0, 1, 32'h0C};
        tbl[2]  = '{0, 2'b01, 2'b01, 1, 2'b01, 2'b00, 1, 1, 0, 1, 32'h0C};
        tbl[3]  = '{0, 2'b00, 2'b00, 0, 2'b00, 2'b00, 0, 0, 0, 1, 32'h0C};
        tbl[4]  = '{0, 2'b11, 2'b11, 1, 2'b00, 2'b00, 0, 0, 0, 0, 32'h0};
        tbl[5]  = '{0, 2'b11, 2'b11, 0, 2'b00, 2'b00, 1, 1, 1, 1, 32'h04};
        tbl[6]  = '{0, 2'b11, 2'b11, 1, 2'b10, 2'b00, 1, 1, 1, 1, 32'h04};
        tbl[7]  = '{0, 2'b01, 2'b01, 0, 2'b00, 2'b00, 0, 0, 1, 1, 32'h04};
        tbl[8]  = '{0, 2'b01, 2'b01, 0, 2'b00, 2'b00, 0, 0, 1, 0, 32'h0};
        tbl[9]  = '{1, 2'b01, 2'b01, 0, 2'b00, 2'b00, 1, 1, 0, 1, 32'h0C};
        tbl[10] = '{0, 2'b11, 2'b11, 1, 2'b00, 2'b00, 0, 0, 0, 0, 32'h0};
        tbl[11] = '{0, 2'b11, 2'b11, 0, 2'b00, 2'b00, 1, 1, 0, 1, 32'h0C};
        tbl[12] = '{0, 2'b00, 2'b00, 0, 2'b00, 2'b00, 0, 0, 0, 1, 32'h0C};
        tbl[13] = '{0, 2'b00, 2'b00, 0, 2'b00, 2'b00, 0, 0, 0, 0, 32'h0};

        bus.m_we    = 2'b10;
        bus.m_addr  = {32'h0000_0004, 32'h0000_000C};
        bus.m_wdata = {32'h0000_0055, 32'h0000_0000};
        bus.m_sel   = 8'hFF;
        bus.wb_rdata = 32'h0000_002A;
        drive(2'b00, 2'b00, 1'b0);
        rst = 1'b1;
        tick();
        tick();
        chk("reset_state", {40'h0, obs_short()}, 80'h0);
        rst = 1'b0;

        // Table: single read, stale ack, two-master handoff, mid-BUSY reset.
        for (int i = 0; i < 14; i++) begin
            rst = tbl[i].rst;
            drive(tbl[i].cyc, tbl[i].stb, tbl[i].ack);
            #1;
            chk($sformatf("vec%0d", i), {40'h0, obs_short()},
                {40'h0, tbl[i].e_ack, tbl[i].e_err, tbl[i].e_cyc, tbl[i].e_stb,
                 tbl[i].e_grant, tbl[i].e_busy, tbl[i].e_addr});
            if (i == 2) chk("read_data", {48'h0, bus.m_rdata}, {48'h0, 32'h0000_002A});
            tick();
        end
        rst = 1'b0;

        // Watchdog: master 1 writes and the slave never acks.
        drive(2'b10, 2'b10, 1'b0);
        tick();
        err_cnt = 0; err_at = -1; ack_cnt = 0; err_vec = '0; cyc_at_err = 1'b1;
        for (int c = 0; c <= 16; c++) begin
            if (c == 0) chk("wdt_wr_drive", {44'h0, bus.wb_stb, bus.wb_we, bus.wb_addr, bus.wb_wdata[1:0]},
                            {44'h0, 1'b1, 1'b1, 32'h0000_0004, 2'b01});
            if (bus.m_err != 0) begin err_cnt++; err_at = c; err_vec = bus.m_err; cyc_at_err = bus.wb_cyc; end
            if (bus.m_ack != 0) ack_cnt++;
            if (c == 16) drive(2'b00, 2'b00, 1'b0);
            tick();
        end
        chk("wdt_err_count", 80'(err_cnt), 80'd1);
        chk("wdt_err_cycle", 80'(err_at), 80'd16);
        chk("wdt_err_vec", {78'h0, err_vec}, {78'h0, 2'b10});
        chk("wdt_cyc_low", {79'h0, cyc_at_err}, 80'h0);
        chk("wdt_no_ack", 80'(ack_cnt), 80'd0);
        chk("wdt_after", {77'h0, bus.m_err, bus.busy}, 80'h0);

        // Ack lands on the last watchdog cycle: ack wins, no error.
        drive(2'b01, 2'b01, 1'b0);
        tick();
        err_cnt = 0; ack_cnt = 0; ack_at = -1;
        for (int c = 0; c <= 17; c++) begin
            bus.wb_ack_ext = (c == 15);
            if (c == 16) drive(2'b00, 2'b00, 1'b0);
            #1;
            if (bus.m_err != 0) err_cnt++;
            if (bus.m_ack != 0) begin ack_cnt++; ack_at = c; end
            tick();
        end
        chk("coll_ack_count", 80'(ack_cnt), 80'd1);
        chk("coll_ack_cycle", 80'(ack_at), 80'd15);
        chk("coll_no_err", 80'(err_cnt), 80'd0);

        // Fairness: both masters request continuously, cyc pulsed per transfer.
        rst = 1'b1;
        drive(2'b00, 2'b00, 1'b0);
        tick();
        rst = 1'b0;
        drive(2'b11, 2'b11, 1'b0);
        for (int t = 0; t < 8; t++) begin
            #1;
            chk($sformatf("rr_idle%0d", t), {79'h0, bus.busy}, 80'h0);
            tick();
            bus.wb_ack_ext = 1'b1;
            #1;
            chk($sformatf("rr_grant%0d", t), {78'h0, bus.m_ack, bus.grant}, {78'h0, 2'(1 << (t % 2)), 1'(t % 2)});
            tick();
            bus.wb_ack_ext = 1'b0;
            bus.m_cyc[t % 2] = 1'b0;
            bus.m_stb[t % 2] = 1'b0;
            #1;
            chk($sformatf("rr_drop%0d", t), {78'h0, bus.busy, bus.wb_cyc}, {78'h0, 1'b1, 1'b0});
            tick();
            drive(2'b11, 2'b11, 1'b0);
        end

        // Randomized traffic against the reference model.
        rst = 1'b1;
        drive(2'b00, 2'b00, 1'b0);
        tick();
        rst = 1'b0;
        model_reset();
        for (int n = 0; n < 3000; n++) begin
            for (int m = 0; m < NM; m++) begin
                if ($urandom_range(0, 7) == 0) bus.m_cyc[m] = ~bus.m_cyc[m];
                bus.m_stb[m] = bus.m_cyc[m] & ($urandom_range(0, 3) != 0);
                bus.m_we[m]  = 1'($urandom_range(0, 1));
            end
            bus.m_addr     = {$urandom(), $urandom()};
            bus.m_wdata    = {$urandom(), $urandom()};
            bus.m_sel      = 8'($urandom());
            bus.wb_ack_ext = ($urandom_range(0, 15) == 0);
            rst            = ($urandom_range(0, 299) == 0);
            #1;
            chk("rand", {3'h0, obs_full()}, {3'h0, model_expect()});
            model_step();
            tick();
        end
        rst = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/wb_ext_arbiter.md
# wb_ext_arbiter

Round-robin arbiter that shares the single external Wishbone slave port between `NUM_M` bus masters, such as the core's external-bus path and a DMA/sequencer engine. It sits between those masters and the external peripheral port (`wb_*` / `wb_ack_ext`). It grants one master per bus cycle and passes that master's signals through. A watchdog aborts any cycle the slave never acknowledges, including writes to slaves that do not ack writes, so a requester can never hang the bus.

## Interface
- `NUM_M`, 2: number of masters, 2..4.
- `TIMEOUT`, 16: cycles a strobe may stay unacknowledged before abort, 2..256.
- `clk` in 1: system clock.
- `rst` in 1: synchronous, active-high reset.
- `m_cyc` in NUM_M: per-master cycle request.
- `m_stb` in NUM_M: per-master strobe.
- `m_we` in NUM_M: per-master write enable.
- `m_addr` in NUM_M*32: packed addresses; master i uses `[32*i +: 32]`.
- `m_wdata` in NUM_M*32: packed write data.
- `m_sel` in NUM_M*4: packed byte selects.
- `m_rdata` out 32: read data, broadcast to all masters.
- `m_ack` out NUM_M: per-master acknowledge.
- `m_err` out NUM_M: per-master timeout error, a one-cycle pulse.
- `wb_cyc`, `wb_stb`, `wb_we` out 1: slave side.
- `wb_addr`, `wb_wdata` out 32: slave side.
- `wb_sel` out 4: slave side.
- `wb_rdata` in 32: slave read data.
- `wb_ack_ext` in 1: slave acknowledge.
- `grant` out clog2(NUM_M) (min 1): index of the current owner.
- `busy` out 1: high in BUSY or ABORT.

## Operation
- **States:** IDLE, BUSY, ABORT. Registered are the state, `grant`, `last` (the most recent owner) and the watchdog counter `wdt` (width clog2(TIMEOUT)+1).
- **IDLE:**
  - The request vector is `m_cyc & m_stb`.
  - When it is nonzero, pick the first requester at or after `last+1`, wrapping modulo NUM_M.
  - Register that index into `grant`, clear `wdt`, and go to BUSY.
  - No slave signals are driven in IDLE.
- **BUSY (slave drive):**
  - `wb_cyc = m_cyc[grant]`, `wb_stb = m_stb[grant]`.
  - `wb_we`, `wb_addr`, `wb_wdata` and `wb_sel` are the granted master's slices.
- **BUSY (response path):**
  - `m_ack[grant] = wb_ack_ext`, passed through combinationally.
  - `m_rdata = wb_rdata` in all states.
  - All other `m_ack` and `m_err` bits are 0.
- **BUSY (watchdog):**
  - `wdt` clears on `wb_ack_ext`.
  - `wdt` increments while `wb_stb` is high and no ack arrives.
  - `wdt` holds while the owner's stb is low.
- **BUSY (exits):**
  - `m_cyc[grant]` low: set `last = grant` and go to IDLE. The ownership is held across multiple strobes as long as cyc stays high.
  - `wdt == TIMEOUT-1` with stb high and no ack this cycle: go to ABORT.
  - An ack in the same cycle as the timeout wins; no abort occurs.
- **ABORT (one cycle):**
  - All slave outputs are 0.
  - `m_err[grant] = 1`, `m_ack` = 0.
  - Then set `last = grant` and go to IDLE, so the other masters get priority next.
- **Boundaries:**
  - An ack arriving in IDLE or ABORT (a stale ack) is ignored and never forwarded.
  - A master's cyc dropping mid-strobe ends ownership; the slave simply sees cyc fall.
  - A single requester re-wins after one IDLE cycle.
- **Reset:**
  - State goes to IDLE, `grant` = 0, `last` = NUM_M-1 so master 0 has first priority, `wdt` = 0.
  - Every output is 0 (`m_rdata` mirrors `wb_rdata`, which is combinational).
  - Reset mid-transaction drops the slave cycle immediately, with no ack or err issued.

## Timing
- Arbitration costs one cycle. A request seen at edge N drives the slave from cycle N+1.
- With a registered-ack slave, a read completes as: request at N, `wb_stb` at N+1, `m_ack` at N+2.
- Back-to-back transfers from different masters have at least one IDLE cycle between owners.
- A timeout asserts `m_err` exactly TIMEOUT cycles after strobe start without an ack. The next grant follows one cycle later.

## Structure
- **Package `wb_arb_pkg`:** state enum `arb_state_t` {IDLE, BUSY, ABORT} and the `WB_AW`/`WB_DW` = 32 constants.
- **Sub-module `rr_pick`:** combinational round-robin selector taking (req vector, last) and producing (idx, valid), parameterized by NUM_M.
- All other logic, including the FSM, watchdog and muxing, stays in `wb_ext_arbiter`.

## Test plan
- **Single-master read:** master 0 reads 0x0C while the slave acks one cycle after stb with 0x0000_002A. Require `m_ack[0]` at request+2, `m_rdata` = 0x2A, `grant` = 0, and `m_ack[1]` never asserted.
- **Round-robin fairness:** both masters hold continuous reads with cyc pulsed per transfer. Require grants to alternate 0, 1, 0, 1 over 8 transfers, with an IDLE cycle between each.
- **Watchdog on write:** master 1 writes 0x04 = 0x55 and the slave never acks, with TIMEOUT = 16. Require `m_err[1]` for exactly one cycle 16 cycles after stb, slave cyc low that cycle, and no `m_ack`.
- **Ack/timeout collision:** the slave acks exactly at `wdt == TIMEOUT-1`. Require `m_ack` asserted and `m_err` never asserted.
- **Reset and stale ack:**
  - Assert `rst` mid-BUSY. Require all outputs 0 next cycle, and master 0 to win a simultaneous request after release.
  - Inject `wb_ack_ext` in IDLE. Require no `m_ack`.
